m_dbus_unit: RTL and testbench



---
 rtl/m_dbus_unit_pkg.sv | 96 +++++++++
 rtl/m_dbus_unit_if.sv | 26 ++
 rtl/m_dbus_check.sv | 63 ++++++
 rtl/m_dbus_unit.sv | 183 ++++++++++++++++++
 tb/tb_m_dbus_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/m_dbus_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m_dbus_unit_pkg
// Brief    : Shared definitions for the M-stage data-bus unit: mem_op codes,
//            default address-map constants, FSM state encoding, lane helpers.
// Revision : 1.0 - initial release
// ============================================================================
package m_dbus_unit_pkg;

  // Memory operation encoding carried by mem_op
  typedef logic [3:0] mem_op_t;
  localparam mem_op_t C_OP_NOPE = 4'd0;
  localparam mem_op_t C_OP_W    = 4'd1;
  localparam mem_op_t C_OP_H    = 4'd2;
  localparam mem_op_t C_OP_B    = 4'd3;
  localparam mem_op_t C_OP_HU   = 4'd4;
  localparam mem_op_t C_OP_BU   = 4'd5;

  // Default address map
  localparam logic [31:0] C_DM_END       = 32'h0000_2fff;
  localparam int unsigned C_NUM_TIMER    = 2;
  localparam logic [31:0] C_TIMER_BASE   = 32'h0000_7f00;
  localparam logic [31:0] C_TIMER_STRIDE = 32'h0000_0010;
  localparam int unsigned C_TIMER_SIZE   = 12;
  localparam int unsigned C_TIMER_CNT_OFF = 8;   // first byte of the read-only count register
  localparam logic [31:0] C_ERRT_BASE    = 32'h0000_7f20;
  localparam int unsigned C_ERRT_SIZE    = 4;
  localparam int unsigned C_MAX_WAIT     = 15;

  // FSM state encoding
  typedef logic [0:0] state_t;
  localparam state_t C_ST_IDLE = 1'b0;
  localparam state_t C_ST_BUSY = 1'b1;

  // Transfer attributes captured at issue, needed when the bus answers
  typedef struct packed {
    mem_op_t    op;
    logic       write;
    logic [1:0] lane;
  } xfer_t;

  // Store lane placement
  typedef struct packed {
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } st_lanes_t;

  // Only these codes start a bus transfer; anything else behaves as nope
  function automatic logic f_is_access(input mem_op_t op);
    return (op == C_OP_W) || (op == C_OP_H) || (op == C_OP_B) ||
           (op == C_OP_HU) || (op == C_OP_BU);
  endfunction

  // Place store data on the byte lanes selected by the low address bits
  function automatic st_lanes_t f_store_lanes(input mem_op_t op, input logic [1:0] lane,
                                              input logic [31:0] data);
    st_lanes_t r;
    case (op)
      C_OP_H, C_OP_HU: begin
        r.byteen = lane[1] ? 4'b1100 : 4'b0011;
        r.wdata  = lane[1] ? {data[15:0], 16'h0000} : {16'h0000, data[15:0]};
      end
      C_OP_B, C_OP_BU: begin
        r.byteen = 4'b0001 << lane;
        r.wdata  = {24'h000000, data[7:0]} << {lane, 3'b000};
      end
      default: begin
        r.byteen = 4'b1111;
        r.wdata  = data;
      end
    endcase
    return r;
  endfunction

  // Select the addressed sub-word from the raw bus word and extend it
  function automatic logic [31:0] f_extend(input mem_op_t op, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] shifted;
    logic [31:0] res;
    half    = lane[1] ? rdata[31:16] : rdata[15:0];
    shifted = rdata >> {lane, 3'b000};
    byt     = shifted[7:0];
    case (op)
      C_OP_H:  res = {{16{half[15]}}, half};
      C_OP_HU: res = {16'h0000, half};
      C_OP_B:  res = {{24{byt[7]}}, byt};
      C_OP_BU: res = {24'h000000, byt};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_dbus_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : m_dbus_unit_if
// Brief    : Ready/valid external data bus between the M-stage unit (master)
//            and the memory/peripheral fabric (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface m_dbus_unit_if;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_byteen, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_byteen, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/m_dbus_check.sv
`default_nettype none
// ============================================================================
// Module   : m_dbus_check
// Brief    : Combinational address-exception decoder: alignment, window
//            membership, sub-word timer access and read-only timer count.
// Revision : 1.0 - initial release
// ============================================================================
module m_dbus_check
  import m_dbus_unit_pkg::*;
#(
  parameter logic [31:0] DM_END       = C_DM_END,
  parameter int unsigned NUM_TIMER    = C_NUM_TIMER,
  parameter logic [31:0] TIMER_BASE   = C_TIMER_BASE,
  parameter logic [31:0] TIMER_STRIDE = C_TIMER_STRIDE,
  parameter int unsigned TIMER_SIZE   = C_TIMER_SIZE,
  parameter logic [31:0] ERRT_BASE    = C_ERRT_BASE
) (
  input  wire         i_valid,
  input  wire  [3:0]  i_op,
  input  wire         i_write,
  input  wire  [31:0] i_addr,
  output logic        o_adel,
  output logic        o_ades
);

  logic [NUM_TIMER-1:0] w_tmr_hit;
  logic [NUM_TIMER-1:0] w_tmr_ro;
  logic                 w_active;
  logic                 w_misalign;
  logic                 w_subword;
  logic                 w_in_dm;
  logic                 w_in_errt;
  logic                 w_in_timer;
  logic [31:0]          w_errt_off;
  logic                 w_viol;

  // One window comparator per timer; offsets below the base wrap to large values
  for (genvar gi = 0; gi < NUM_TIMER; gi++) begin : g_timer
    logic [31:0] w_off;
    assign w_off         = i_addr - (TIMER_BASE + TIMER_STRIDE * 32'(gi));
    assign w_tmr_hit[gi] = (w_off < TIMER_SIZE);
    assign w_tmr_ro[gi]  = w_tmr_hit[gi] && (w_off >= C_TIMER_CNT_OFF);
  end

  assign w_active   = i_valid && f_is_access(i_op);
  assign w_misalign = ((i_op == C_OP_W) && (i_addr[1:0] != 2'b00)) ||
                      (((i_op == C_OP_H) || (i_op == C_OP_HU)) && i_addr[0]);
  assign w_subword  = (i_op != C_OP_W);
  assign w_in_dm    = (i_addr <= DM_END);
  assign w_errt_off = i_addr - ERRT_BASE;
  assign w_in_errt  = (w_errt_off < C_ERRT_SIZE);
  assign w_in_timer = |w_tmr_hit;

  assign w_viol = w_misalign
                | !(w_in_dm || w_in_timer || w_in_errt)
                | (w_in_timer && w_subword)
                | (i_write && (|w_tmr_ro));

  assign o_adel = w_active && !i_write && w_viol;
  assign o_ades = w_active &&  i_write && w_viol;

endmodule
`default_nettype wire

// File: rtl/m_dbus_unit.sv
`default_nettype none
// ============================================================================
// Module   : m_dbus_unit
// Brief    : Memory-stage data-bus unit. Checks address exceptions, issues
//            one ready/valid bus transfer per memory instruction, stalls the
//            pipeline until it completes and registers extended load data.
//            Optional feature macro: DBUS_TIMEOUT_EN (bus wait timeout).
// Revision : 1.0 - initial release
// ============================================================================
module m_dbus_unit
  import m_dbus_unit_pkg::*;
#(
  parameter logic [31:0] DM_END       = C_DM_END,
  parameter int unsigned NUM_TIMER    = C_NUM_TIMER,
  parameter logic [31:0] TIMER_BASE   = C_TIMER_BASE,
  parameter logic [31:0] TIMER_STRIDE = C_TIMER_STRIDE,
  parameter int unsigned TIMER_SIZE   = C_TIMER_SIZE,
  parameter logic [31:0] ERRT_BASE    = C_ERRT_BASE
`ifdef DBUS_TIMEOUT_EN
  ,
  // The wait limit only exists when the timeout logic is built
  parameter int unsigned MAX_WAIT     = C_MAX_WAIT
`endif
) (
  input  wire               clk,
  input  wire               reset_n,
  input  wire               mem_valid,
  input  wire  [3:0]        mem_op,
  input  wire               mem_write,
  input  wire               flush,
  input  wire  [31:0]       addr,
  input  wire  [31:0]       st_data,
  m_dbus_unit_if.master     bus,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              ld_done,
  output logic              err_adel,
  output logic              err_ades,
  output logic              err_timeout
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_bus_valid;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_byteen;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_ld_data;
  logic        r_ld_done;
  xfer_t       r_xfer;
  st_lanes_t   w_st;
  logic        w_issue;
  logic        w_ready_hit;
  logic        w_timeout;

  m_dbus_check #(
    .DM_END       (DM_END),
    .NUM_TIMER    (NUM_TIMER),
    .TIMER_BASE   (TIMER_BASE),
    .TIMER_STRIDE (TIMER_STRIDE),
    .TIMER_SIZE   (TIMER_SIZE),
    .ERRT_BASE    (ERRT_BASE)
  ) u_check (
    .i_valid (mem_valid),
    .i_op    (mem_op),
    .i_write (mem_write),
    .i_addr  (addr),
    .o_adel  (err_adel),
    .o_ades  (err_ades)
  );

  // A flush or an exception suppresses issue; a transfer already on the bus is unaffected
  assign w_issue     = (r_state == C_ST_IDLE) && mem_valid && f_is_access(mem_op) &&
                       !err_adel && !err_ades && !flush;
  assign w_ready_hit = (r_state == C_ST_BUSY) && bus.bus_ready;
  assign w_st        = f_store_lanes(mem_op, addr[1:0], st_data);

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned C_WAIT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(MAX_WAIT - 1);

  logic [C_WAIT_W-1:0] r_wait;
  logic                r_err_timeout;

  // The last unanswered BUSY cycle is the one where the counter already holds MAX_WAIT-1
  assign w_timeout = (r_state == C_ST_BUSY) && !bus.bus_ready && (r_wait == C_WAIT_LAST);

  // Count unanswered BUSY cycles and raise a one-cycle timeout pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if ((r_state == C_ST_BUSY) && !bus.bus_ready && !w_timeout) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  // Without the timeout option BUSY waits for the bus indefinitely
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: if (w_issue) w_next_state = C_ST_BUSY;
      C_ST_BUSY: if (bus.bus_ready || w_timeout) w_next_state = C_ST_IDLE;
      default:   w_next_state = C_ST_IDLE;
    endcase
  end

  // Stall from the issue cycle up to, but not including, the cycle the transfer ends
  always_comb begin
    stall = 1'b0;
    case (r_state)
      C_ST_IDLE: stall = w_issue;
      C_ST_BUSY: stall = !(bus.bus_ready || w_timeout);
      default:   stall = 1'b0;
    endcase
  end

  // Bus request registers, issue-time attributes and the registered load result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_valid  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_byteen <= '0;
      r_bus_wdata  <= '0;
      r_ld_data    <= '0;
      r_ld_done    <= 1'b0;
      r_xfer       <= '0;
    end else begin
      r_ld_done <= 1'b0;
      if (w_issue) begin
        r_bus_valid  <= 1'b1;
        r_bus_addr   <= {addr[31:2], 2'b00};
        r_bus_byteen <= mem_write ? w_st.byteen : 4'b0000;
        r_bus_wdata  <= mem_write ? w_st.wdata  : 32'h0000_0000;
        r_xfer       <= '{op: mem_op, write: mem_write, lane: addr[1:0]};
      end else if (w_ready_hit) begin
        // Byte enables return to zero so an idle bus never advertises a write
        r_bus_valid  <= 1'b0;
        r_bus_byteen <= 4'b0000;
        r_bus_wdata  <= 32'h0000_0000;
        if (!r_xfer.write) begin
          r_ld_data <= f_extend(r_xfer.op, r_xfer.lane, bus.bus_rdata);
          r_ld_done <= 1'b1;
        end
      end else if (w_timeout) begin
        r_bus_valid  <= 1'b0;
        r_bus_byteen <= 4'b0000;
        r_bus_wdata  <= 32'h0000_0000;
        r_ld_data    <= 32'h0000_0000;
      end
    end
  end

  assign bus.bus_valid  = r_bus_valid;
  assign bus.bus_addr   = r_bus_addr;
  assign bus.bus_byteen = r_bus_byteen;
  assign bus.bus_wdata  = r_bus_wdata;
  assign ld_data        = r_ld_data;
  assign ld_done        = r_ld_done;

endmodule
`default_nettype wire

// File: tb/tb_m_dbus_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_dbus_unit
// Brief    : Scoreboard bench for m_dbus_unit. Directed accesses push the
//            expected bus request / load result / timeout into queues; a
//            negedge monitor pops and compares whenever the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_dbus_unit;
  import m_dbus_unit_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_req_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid, mem_write, flush;
  logic [3:0]  mem_op;
  logic [31:0] addr, st_data;
  logic        stall, ld_done, err_adel, err_ades, err_timeout;
  logic [31:0] ld_data;

  int n_checks = 0;
  int n_errors = 0;

  bus_req_t    q_bus[$];
  logic [31:0] q_ld[$];
  logic [31:0] q_to[$];
  bus_req_t    m_req;
  logic [31:0] m_val;
  logic        prev_bv = 1'b0;

  m_dbus_unit_if bus_if();

  m_dbus_unit u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_valid   (mem_valid),
    .mem_op      (mem_op),
    .mem_write   (mem_write),
    .flush       (flush),
    .addr        (addr),
    .st_data     (st_data),
    .bus         (bus_if),
    .stall       (stall),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .err_adel    (err_adel),
    .err_ades    (err_ades),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event, value %h, required none", nm, act);
  endtask

  // Monitor: compares bus requests, load results and timeouts against the queues
  always @(negedge clk) begin
    if (bus_if.bus_valid && !prev_bv) begin
      if (q_bus.size() == 0) unexpected("bus_req", bus_if.bus_addr);
      else begin
        m_req = q_bus.pop_front();
        chk("bus_addr", bus_if.bus_addr, m_req.addr);
        chk("bus_byteen", {28'h0, bus_if.bus_byteen}, {28'h0, m_req.be});
        chk("bus_wdata", bus_if.bus_wdata, m_req.wd);
      end
    end
    prev_bv <= bus_if.bus_valid;
    if (ld_done) begin
      if (q_ld.size() == 0) unexpected("ld_done", ld_data);
      else begin
        m_val = q_ld.pop_front();
        chk("ld_data", ld_data, m_val);
      end
    end
    if (err_timeout) begin
      if (q_to.size() == 0) unexpected("err_timeout", ld_data);
      else begin
        m_val = q_to.pop_front();
        chk("timeout_ld_data", ld_data, m_val);
        chk("timeout_ld_done", {31'h0, ld_done}, 32'h0);
      end
    end
  end

  // One complete access: issue, 'waits' unanswered BUSY cycles, then bus_ready.
  // Entered and left just after a rising edge.
  task automatic access(input string nm, input logic [3:0] op, input logic wr,
                        input logic [31:0] a, input logic [31:0] sd, input int waits,
                        input logic [31:0] rd, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic [31:0] e_ld, input int e_stall);
    int nst;
    nst = 0;
    q_bus.push_back('{e_addr, e_be, e_wd});
    if (!wr) q_ld.push_back(e_ld);
    mem_valid = 1'b1; mem_op = op; mem_write = wr; addr = a; st_data = sd;
    bus_if.bus_ready = 1'b0;
    @(negedge clk); if (stall) nst++;
    @(posedge clk); #1;
    for (int k = 0; k < waits; k++) begin
      @(negedge clk); if (stall) nst++;
      @(posedge clk); #1;
    end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = rd;
    @(negedge clk); if (stall) nst++;
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0; mem_valid = 1'b0; mem_op = C_OP_NOPE;
    chk({nm, "_stall_cycles"}, nst, e_stall);
  endtask

  // Present an access that must not issue; check error flags, stall and bus.
  task automatic no_issue(input string nm, input logic [3:0] op, input logic wr,
                          input logic [31:0] a, input logic fl,
                          input logic e_adel, input logic e_ades);
    mem_valid = 1'b1; mem_op = op; mem_write = wr; addr = a; st_data = 32'h1234_5678;
    flush = fl;
    @(negedge clk);
    chk({nm, "_adel"}, {31'h0, err_adel}, {31'h0, e_adel});
    chk({nm, "_ades"}, {31'h0, err_ades}, {31'h0, e_ades});
    chk({nm, "_stall"}, {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    chk({nm, "_bus_valid"}, {31'h0, bus_if.bus_valid}, 32'h0);
    chk({nm, "_byteen"}, {28'h0, bus_if.bus_byteen}, 32'h0);
    mem_valid = 1'b0; mem_op = C_OP_NOPE; flush = 1'b0;
  endtask

  initial begin
    mem_valid = 1'b0; mem_op = C_OP_NOPE; mem_write = 1'b0; flush = 1'b0;
    addr = '0; st_data = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_bus_valid", {31'h0, bus_if.bus_valid}, 32'h0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_byteen", {28'h0, bus_if.bus_byteen}, 32'h0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_ld_done", {31'h0, ld_done}, 32'h0);
    chk("rst_err_timeout", {31'h0, err_timeout}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Loads with lane selection and extension
    access("lw", C_OP_W, 1'b0, 32'h0000_0104, 32'h0, 2, 32'hdead_beef,
           32'h0000_0104, 4'h0, 32'h0, 32'hdead_beef, 3);
    access("lb", C_OP_B, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h8012_3456,
           32'h0000_0100, 4'h0, 32'h0, 32'hffff_ff80, 1);
    access("lbu", C_OP_BU, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h8012_3456,
           32'h0000_0100, 4'h0, 32'h0, 32'h0000_0080, 2);
    access("lh_hi", C_OP_H, 1'b0, 32'h0000_0106, 32'h0, 0, 32'h8001_7fff,
           32'h0000_0104, 4'h0, 32'h0, 32'hffff_8001, 1);
    access("lhu_lo", C_OP_HU, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h1234_f00d,
           32'h0000_0104, 4'h0, 32'h0, 32'h0000_f00d, 1);
    access("lh_lo", C_OP_H, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0000_f00d,
           32'h0000_0100, 4'h0, 32'h0, 32'hffff_f00d, 1);
    access("lw_tcount", C_OP_W, 1'b0, 32'h0000_7f08, 32'h0, 0, 32'h0000_0011,
           32'h0000_7f08, 4'h0, 32'h0, 32'h0000_0011, 1);

    // Stores with byte-lane placement
    access("sh", C_OP_H, 1'b1, 32'h0000_0202, 32'h1234_abcd, 1, 32'h0,
           32'h0000_0200, 4'b1100, 32'habcd_0000, 32'h0, 2);
    access("sb", C_OP_B, 1'b1, 32'h0000_0301, 32'h0000_00a5, 0, 32'h0,
           32'h0000_0300, 4'b0010, 32'h0000_a500, 32'h0, 1);
    access("sw_dm_end", C_OP_W, 1'b1, 32'h0000_2ffc, 32'hcafe_f00d, 0, 32'h0,
           32'h0000_2ffc, 4'b1111, 32'hcafe_f00d, 32'h0, 1);
    access("sw_timer1", C_OP_W, 1'b1, 32'h0000_7f14, 32'h0000_0042, 0, 32'h0,
           32'h0000_7f14, 4'b1111, 32'h0000_0042, 32'h0, 1);
    access("sw_errt", C_OP_W, 1'b1, 32'h0000_7f20, 32'h0000_0007, 0, 32'h0,
           32'h0000_7f20, 4'b1111, 32'h0000_0007, 32'h0, 1);

    // Exceptions, flush and nope: nothing reaches the bus
    no_issue("sw_tcount", C_OP_W, 1'b1, 32'h0000_7f08, 1'b0, 1'b0, 1'b1);
    no_issue("lh_timer", C_OP_H, 1'b0, 32'h0000_7f00, 1'b0, 1'b1, 1'b0);
    no_issue("lw_hole", C_OP_W, 1'b0, 32'h0000_4000, 1'b0, 1'b1, 1'b0);
    no_issue("lw_past_dm", C_OP_W, 1'b0, 32'h0000_3000, 1'b0, 1'b1, 1'b0);
    no_issue("lw_misalign", C_OP_W, 1'b0, 32'h0000_0102, 1'b0, 1'b1, 1'b0);
    no_issue("sh_misalign", C_OP_H, 1'b1, 32'h0000_0201, 1'b0, 1'b0, 1'b1);
    no_issue("sw_gap", C_OP_W, 1'b1, 32'h0000_7f1c, 1'b0, 1'b0, 1'b1);
    no_issue("lw_past_errt", C_OP_W, 1'b0, 32'h0000_7f24, 1'b0, 1'b1, 1'b0);
    no_issue("sb_timer", C_OP_B, 1'b1, 32'h0000_7f14, 1'b0, 1'b0, 1'b1);
    no_issue("sw_flush", C_OP_W, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    no_issue("nope", C_OP_NOPE, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    // Reset while BUSY: the request drops at once and no load result appears
    q_bus.push_back('{32'h0000_0040, 4'h0, 32'h0});
    mem_valid = 1'b1; mem_op = C_OP_W; mem_write = 1'b0; addr = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_op = C_OP_NOPE;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_bus_valid", {31'h0, bus_if.bus_valid}, 32'h0);
    chk("midrst_ld_done", {31'h0, ld_done}, 32'h0);
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ld_data", ld_data, 32'h0);
    access("lw_after_rst", C_OP_W, 1'b0, 32'h0000_2ffc, 32'h0, 0, 32'h0bad_f00d,
           32'h0000_2ffc, 4'h0, 32'h0, 32'h0bad_f00d, 1);

`ifdef DBUS_TIMEOUT_EN
    begin
      int nst;
      logic done;
      nst = 0; done = 1'b0;
      q_bus.push_back('{32'h0, 4'h0, 32'h0});
      q_to.push_back(32'h0);
      mem_valid = 1'b1; mem_op = C_OP_W; mem_write = 1'b0; addr = 32'h0;
      bus_if.bus_ready = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        @(negedge clk);
        if (stall) nst++; else done = 1'b1;
        @(posedge clk); #1;
      end
      mem_valid = 1'b0; mem_op = C_OP_NOPE;
      chk("timeout_bound", {31'h0, done}, 32'h1);
      chk("timeout_stall_cycles", nst, 15);
    end
`else
    access("lw_long_wait", C_OP_W, 1'b0, 32'h0, 32'h0, 20, 32'h5a5a_0001,
           32'h0, 4'h0, 32'h0, 32'h5a5a_0001, 21);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_empty", q_bus.size(), 32'h0);
    chk("ld_queue_empty", q_ld.size(), 32'h0);
    chk("timeout_queue_empty", q_to.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
